// File: rtl/alarm_pkg.sv
// Shared definitions for the UART time-set command receiver.
// Holds ASCII constants, the parser state encoding and the bit-period helper.
package alarm_pkg;

  localparam logic [7:0] ASC_T     = 8'h54;
  localparam logic [7:0] ASC_t     = 8'h74;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_5     = 8'h35;
  localparam logic [7:0] ASC_9     = 8'h39;

  typedef enum logic [2:0] {
    P_IDLE = 3'd0,
    P_M10  = 3'd1,
    P_M1   = 3'd2,
    P_COL  = 3'd3,
    P_S10  = 3'd4,
    P_S1   = 3'd5,
    P_END  = 3'd6,
    P_DISC = 3'd7
  } pstate_e;

  // Truncating division, so slightly fast baud clocks round toward shorter bits.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_time_cmd_rx_if.sv
// Serial line plus time-preset outputs of the UART command receiver.
// slave = receiver side, master = line driver / consumer side.
interface uart_time_cmd_rx_if;
  logic       rx;
  logic       load_valid;
  logic [2:0] load_min_tens;
  logic [3:0] load_min_ones;
  logic [2:0] load_sec_tens;
  logic [3:0] load_sec_ones;
  logic       frame_err;
  logic       cmd_err;
  logic       busy;

  modport slave (
    input  rx,
    output load_valid, load_min_tens, load_min_ones, load_sec_tens, load_sec_ones,
    output frame_err, cmd_err, busy
  );

  modport master (
    output rx,
    input  load_valid, load_min_tens, load_min_ones, load_sec_tens, load_sec_ones,
    input  frame_err, cmd_err, busy
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop rx synchroniser, centre-sampling byte FSM.
// Emits each good byte for one cycle, or a frame_err pulse when the stop bit is low.
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [1:0]       r_sync;
  logic             r_prev;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_valid;
  logic             r_ferr;
  logic             w_rx;
  logic             w_tick;

  assign w_rx   = r_sync[1];
  assign w_tick = (r_cnt == CNT_ZERO);

  // Preset to idle-high so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_rx};
      r_prev <= w_rx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_ZERO;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_rx && r_prev) begin
            r_state <= S_START;
            r_cnt   <= CNT_HALF;
          end
        end
        S_START: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else if (!w_rx) begin
            r_state <= S_DATA;
            r_cnt   <= CNT_FULL;
            r_bit   <= 3'd0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            r_shift <= {w_rx, r_shift[7:1]};
            r_cnt   <= CNT_FULL;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end
        end
        S_STOP: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            r_valid <= w_rx;
            r_ferr  <= !w_rx;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_data       = r_shift;
  assign o_data_valid = r_valid;
  assign o_frame_err  = r_ferr;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: rtl/uart_time_cmd_rx.sv
// Parses "T<m10><m1>:<s10><s1><CR|LF>" from the UART byte stream and
// issues a one-cycle load strobe with four BCD digits for the time counters.
module uart_time_cmd_rx
  import alarm_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic              clk,
  input  logic              rst,
  uart_time_cmd_rx_if.slave bus
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

  logic [7:0] w_data;
  logic       w_data_valid;
  logic       w_frame_err;
  logic       w_byte_busy;
  logic       w_is_t;
  logic       w_is_term;
  logic       w_is_d5;
  logic       w_is_d9;

  pstate_e    r_pstate;
  logic [2:0] r_sh_m10;
  logic [3:0] r_sh_m1;
  logic [2:0] r_sh_s10;
  logic [3:0] r_sh_s1;
  logic [2:0] r_min_tens;
  logic [3:0] r_min_ones;
  logic [2:0] r_sec_tens;
  logic [3:0] r_sec_ones;
  logic       r_load_valid;
  logic       r_cmd_err;
  logic       r_frame_err;
  logic       r_busy;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk          (clk),
    .rst          (rst),
    .i_rx         (bus.rx),
    .o_data       (w_data),
    .o_data_valid (w_data_valid),
    .o_frame_err  (w_frame_err),
    .o_busy       (w_byte_busy)
  );

  assign w_is_t    = (w_data == ASC_T) || (w_data == ASC_t);
  assign w_is_term = (w_data == ASC_CR) || (w_data == ASC_LF);
  assign w_is_d5   = (w_data >= ASC_0) && (w_data <= ASC_5);
  assign w_is_d9   = (w_data >= ASC_0) && (w_data <= ASC_9);

  // One state step per received byte; in-range ASCII digits carry their value in the low nibble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pstate     <= P_IDLE;
      r_sh_m10     <= 3'd0;
      r_sh_m1      <= 4'd0;
      r_sh_s10     <= 3'd0;
      r_sh_s1      <= 4'd0;
      r_min_tens   <= 3'd0;
      r_min_ones   <= 4'd0;
      r_sec_tens   <= 3'd0;
      r_sec_ones   <= 4'd0;
      r_load_valid <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_load_valid <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_frame_err  <= w_frame_err;
      r_busy       <= w_byte_busy || (r_pstate != P_IDLE);
      if (w_frame_err) begin
        if (r_pstate != P_IDLE) r_pstate <= P_DISC;
      end else if (w_data_valid) begin
        if (w_is_t && (r_pstate != P_DISC)) begin
          r_pstate <= P_M10;
        end else begin
          case (r_pstate)
            P_IDLE: r_pstate <= P_IDLE;
            P_M10: begin
              if (w_is_d5) begin r_sh_m10 <= w_data[2:0]; r_pstate <= P_M1; end
              else begin r_cmd_err <= 1'b1; r_pstate <= P_DISC; end
            end
            P_M1: begin
              if (w_is_d9) begin r_sh_m1 <= w_data[3:0]; r_pstate <= P_COL; end
              else begin r_cmd_err <= 1'b1; r_pstate <= P_DISC; end
            end
            P_COL: begin
              if (w_data == ASC_COLON) r_pstate <= P_S10;
              else begin r_cmd_err <= 1'b1; r_pstate <= P_DISC; end
            end
            P_S10: begin
              if (w_is_d5) begin r_sh_s10 <= w_data[2:0]; r_pstate <= P_S1; end
              else begin r_cmd_err <= 1'b1; r_pstate <= P_DISC; end
            end
            P_S1: begin
              if (w_is_d9) begin r_sh_s1 <= w_data[3:0]; r_pstate <= P_END; end
              else begin r_cmd_err <= 1'b1; r_pstate <= P_DISC; end
            end
            P_END: begin
              if (w_is_term) begin
                r_min_tens   <= r_sh_m10;
                r_min_ones   <= r_sh_m1;
                r_sec_tens   <= r_sh_s10;
                r_sec_ones   <= r_sh_s1;
                r_load_valid <= 1'b1;
                r_pstate     <= P_IDLE;
              end else begin
                r_cmd_err <= 1'b1;
                r_pstate  <= P_DISC;
              end
            end
            P_DISC: begin
              if (w_is_term) r_pstate <= P_IDLE;
            end
            default: r_pstate <= P_DISC;
          endcase
        end
      end
    end
  end

  assign bus.load_valid    = r_load_valid;
  assign bus.load_min_tens = r_min_tens;
  assign bus.load_min_ones = r_min_ones;
  assign bus.load_sec_tens = r_sec_tens;
  assign bus.load_sec_ones = r_sec_ones;
  assign bus.frame_err     = r_frame_err;
  assign bus.cmd_err       = r_cmd_err;
  assign bus.busy          = r_busy;

endmodule
